// File: rtl/ov7670_sccb_config_ctrl.sv
// OV7670 configuration sequencer: walks the register ROM and writes each
// entry to the sensor as a 3-phase SCCB write on bit-banged SIOC/SIOD.
//
// state    | meaning
// IDLE     | waiting for start
// RESEND   | pulse rom_resend (ROM address to 0)
// WAIT_ROM | wait ROM_WAIT cycles for registered ROM data
// DECODE   | end of table, delay entry, or latch command
// DELAY    | bus idle for DELAY_CYCLES
// START    | SIOC high, SIOD low for one half-period
// TX       | 27 bits, low half then high half each
// STOP     | three half-periods releasing the bus
// ADVANCE  | pulse rom_advance (ROM address +1)
// DONE     | table fully written
module ov7670_sccb_config_ctrl #(
  parameter int unsigned SIOC_HALF_DIV = 250,
  parameter int unsigned DELAY_CYCLES  = 1000000,
  parameter logic [7:0]  DEV_ADDR      = 8'h42,
  parameter int unsigned ROM_WAIT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] rom_command,
  input  logic        rom_finished,
  output logic        rom_resend,
  output logic        rom_advance,
  output logic        sioc,
  output logic        siod_o,
  output logic        siod_oe,
  output logic        busy,
  output logic        done,
  output logic [7:0]  cmd_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_RESEND, S_WAIT_ROM, S_DECODE, S_DELAY,
    S_START, S_TX, S_STOP, S_ADVANCE, S_DONE
  } state_t;

  localparam logic [31:0] HALF_LOAD  = 32'(SIOC_HALF_DIV - 1);
  localparam logic [31:0] DELAY_LOAD = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0] WAIT_LOAD  = 32'(ROM_WAIT - 1);

  state_t      state, state_nx;
  logic [31:0] tmr, tmr_nx;
  logic [4:0]  bit_idx, bit_idx_nx;
  logic        half, half_nx;
  logic [1:0]  stop_ph, stop_ph_nx;
  logic [15:0] cmd_q, cmd_q_nx;
  logic [7:0]  cmd_count_nx;
  logic        tc;
  logic        dont_care;
  logic [26:0] tx_word;

  assign tc        = (tmr == 32'd0);
  assign tx_word   = {DEV_ADDR, 1'b1, cmd_q[15:8], 1'b1, cmd_q[7:0], 1'b1};
  assign dont_care = (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      bit_idx   <= '0;
      half      <= 1'b0;
      stop_ph   <= '0;
      cmd_q     <= '0;
      cmd_count <= '0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      bit_idx   <= bit_idx_nx;
      half      <= half_nx;
      stop_ph   <= stop_ph_nx;
      cmd_q     <= cmd_q_nx;
      cmd_count <= cmd_count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    tmr_nx       = tc ? tmr : tmr - 32'd1;
    bit_idx_nx   = bit_idx;
    half_nx      = half;
    stop_ph_nx   = stop_ph;
    cmd_q_nx     = cmd_q;
    cmd_count_nx = cmd_count;
    rom_resend   = 1'b0;
    rom_advance  = 1'b0;
    sioc         = 1'b1;
    siod_o       = 1'b1;
    siod_oe      = 1'b1;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx     = S_RESEND;
          cmd_count_nx = '0;
        end
      end
      S_RESEND: begin
        rom_resend = 1'b1;
        state_nx   = S_WAIT_ROM;
        tmr_nx     = WAIT_LOAD;
      end
      S_WAIT_ROM: begin
        if (tc) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (rom_finished) begin
          state_nx = S_DONE;
        end else if (rom_command == 16'hFFF0) begin
          state_nx = S_DELAY;
          tmr_nx   = DELAY_LOAD;
        end else begin
          cmd_q_nx = rom_command;
          state_nx = S_START;
          tmr_nx   = HALF_LOAD;
        end
      end
      S_DELAY: begin
        if (tc) state_nx = S_ADVANCE;
      end
      S_START: begin
        siod_o = 1'b0;
        if (tc) begin
          state_nx   = S_TX;
          tmr_nx     = HALF_LOAD;
          bit_idx_nx = '0;
          half_nx    = 1'b0;
        end
      end
      S_TX: begin
        // data only moves when bit_idx moves, i.e. on entry to a low half
        sioc    = half;
        siod_o  = tx_word[5'd26 - bit_idx];
        siod_oe = !dont_care;
        if (tc) begin
          tmr_nx = HALF_LOAD;
          if (!half) begin
            half_nx = 1'b1;
          end else if (bit_idx == 5'd26) begin
            state_nx   = S_STOP;
            stop_ph_nx = '0;
          end else begin
            bit_idx_nx = bit_idx + 5'd1;
            half_nx    = 1'b0;
          end
        end
      end
      S_STOP: begin
        sioc   = (stop_ph != 2'd0);
        siod_o = (stop_ph == 2'd2);
        if (tc) begin
          tmr_nx = HALF_LOAD;
          if (stop_ph == 2'd2) begin
            state_nx = S_ADVANCE;
            if (cmd_count != 8'hFF) cmd_count_nx = cmd_count + 8'd1;
          end else begin
            stop_ph_nx = stop_ph + 2'd1;
          end
        end
      end
      S_ADVANCE: begin
        rom_advance = 1'b1;
        state_nx    = S_WAIT_ROM;
        tmr_nx      = WAIT_LOAD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ov7670_sccb_config_ctrl.sv
// Directed bench for ov7670_sccb_config_ctrl with a registered ROM model and
// an SCCB bus monitor that decodes frames from the SIOC/SIOD pins.
module tb_ov7670_sccb_config_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rom_command;
  logic        rom_finished;
  logic        rom_resend, rom_advance;
  logic        sioc, siod_o, siod_oe;
  logic        busy, done;
  logic [7:0]  cmd_count;

  ov7670_sccb_config_ctrl #(
    .SIOC_HALF_DIV(4),
    .DELAY_CYCLES(100),
    .DEV_ADDR(8'h42),
    .ROM_WAIT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_command(rom_command), .rom_finished(rom_finished),
    .rom_resend(rom_resend), .rom_advance(rom_advance),
    .sioc(sioc), .siod_o(siod_o), .siod_oe(siod_oe),
    .busy(busy), .done(done), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] FULL_TAB [0:73] = '{
    16'h1280, 16'hFFF0, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h8C00, 16'h0400,
    16'h4010, 16'h3A04, 16'h1438, 16'h4FB3, 16'h50B3, 16'h5100, 16'h523D, 16'h53A7,
    16'h54E4, 16'h589E, 16'h3DC0, 16'h1100, 16'h1711, 16'h1861, 16'h32A4, 16'h1903,
    16'h1A7B, 16'h030A, 16'h0E61, 16'h0F4B, 16'h1602, 16'h1E37, 16'h2102, 16'h2291,
    16'h2907, 16'h330B, 16'h350B, 16'h371D, 16'h3871, 16'h392A, 16'h3C78, 16'h4D40,
    16'h4E20, 16'h6900, 16'h6B4A, 16'h7410, 16'h8D4F, 16'h8E00, 16'h8F00, 16'h9000,
    16'h9100, 16'h9600, 16'h9A00, 16'hB084, 16'hB10C, 16'hB20E, 16'hB382, 16'hB80A,
    16'h7A20, 16'h7B10, 16'h7C1E, 16'h7D35, 16'h7E5A, 16'h7F69, 16'h8076, 16'h8180,
    16'h8288, 16'h838F, 16'h8496, 16'h85A3, 16'h86AF, 16'h87C4, 16'h88D7, 16'h89E8,
    16'h13E0, 16'h0000
  };

  // registered-address, registered-data ROM
  logic [15:0] rom_mem [0:127];
  logic [6:0]  rom_addr = '0;
  logic [15:0] rom_q = 16'hFFFF;
  always @(posedge clk) begin
    if (rom_resend) rom_addr <= '0;
    else if (rom_advance) rom_addr <= rom_addr + 7'd1;
    rom_q <= rom_mem[rom_addr];
  end
  assign rom_command  = rom_q;
  assign rom_finished = (rom_q == 16'hFFFF);

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] d;
    logic [31:0] o;
    int          n;
    int          sc;
  } frame_t;

  frame_t      frames[$];
  int          n_resend = 0, n_both = 0, gap_lows = 0;
  int          first_adv_cyc = -1, last_adv_cyc = -1;
  logic        in_frame = 1'b0, pend = 1'b0, pend_d, pend_oe;
  logic        prev_sioc = 1'b1, prev_sda = 1'b1, sda;
  logic [31:0] dbits, obits;
  int          nbits = 0, start_cyc = 0;

  always @(negedge clk) begin
    sda = siod_oe ? siod_o : 1'b1;
    if (rst) begin
      in_frame = 1'b0;
      pend     = 1'b0;
    end else begin
      if (rom_resend) n_resend++;
      if (rom_advance) begin
        last_adv_cyc = cyc;
        if (first_adv_cyc < 0) first_adv_cyc = cyc;
      end
      if (rom_resend && rom_advance) n_both++;
      if (!in_frame && busy && !sioc) gap_lows++;
      if (prev_sioc && sioc && prev_sda && !sda) begin
        in_frame = 1'b1; nbits = 0; dbits = '0; obits = '0; pend = 1'b0; start_cyc = cyc;
      end else if (in_frame && prev_sioc && sioc && !prev_sda && sda) begin
        frames.push_back('{d: dbits, o: obits, n: nbits, sc: start_cyc});
        in_frame = 1'b0;
        pend     = 1'b0;
      end else if (in_frame && !prev_sioc && sioc) begin
        pend = 1'b1; pend_d = siod_o; pend_oe = siod_oe;
      end else if (in_frame && prev_sioc && !sioc && pend) begin
        dbits = {dbits[30:0], pend_d};
        obits = {obits[30:0], pend_oe};
        nbits++;
        pend = 1'b0;
      end
    end
    prev_sioc = sioc;
    prev_sda  = sda;
  end

  int n_chk = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic load4(input logic [15:0] a, b, c, d);
    for (int i = 0; i < 128; i++) rom_mem[i] = 16'hFFFF;
    rom_mem[0] = a; rom_mem[1] = b; rom_mem[2] = c; rom_mem[3] = d;
  endtask

  task automatic load_full();
    for (int i = 0; i < 128; i++) begin
      if (i < 74) rom_mem[i] = FULL_TAB[i];
      else        rom_mem[i] = 16'hFFFF;
    end
  endtask

  task automatic clear_mon();
    frames.delete();
    n_resend = 0; gap_lows = 0; first_adv_cyc = -1; last_adv_cyc = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done !== 1'b1 && i < budget) begin @(negedge clk); i++; end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  // number of frames that disagree with the write entries of rom_mem
  task automatic frames_vs_rom(output int nmis);
    int j = 0;
    nmis = 0;
    for (int i = 0; i < 128 && rom_mem[i] != 16'hFFFF; i++) begin
      if (rom_mem[i] != 16'hFFF0) begin
        if (j >= frames.size()) nmis++;
        else if (frames[j].n != 27 || frames[j].o[26:0] != 27'h7FBFDFE ||
                 frames[j].d[26:19] != 8'h42 || frames[j].d[17:10] != rom_mem[i][15:8] ||
                 frames[j].d[8:1] != rom_mem[i][7:0]) nmis++;
        j++;
      end
    end
    if (j != frames.size()) nmis++;
  endtask

  initial begin
    int i, nmis, lows;
    load4(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // power-on reset
    #2 rst = 1'b1;
    #1;
    check("por_sioc", 32'(sioc), 32'd1);
    check("por_siod", 32'(siod_o), 32'd1);
    check("por_oe", 32'(siod_oe), 32'd1);
    check("por_busy_done", {30'd0, busy, done}, 32'd0);
    check("por_count", 32'(cmd_count), 32'd0);
    check("por_pulses", {30'd0, rom_resend, rom_advance}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset in the middle of a transfer
    clear_mon();
    pulse_start();
    i = 0;
    while (!(in_frame && nbits >= 5) && i < 5000) begin @(negedge clk); i++; end
    check("midtx_reached", 32'(in_frame && nbits >= 5), 32'd1);
    @(posedge clk); #2 rst = 1'b1; #1;
    check("midtx_rst_bus", {29'd0, sioc, siod_o, siod_oe}, 32'h7);
    check("midtx_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    clear_mon();
    lows = 0;
    repeat (50) begin @(negedge clk); if (!sioc || busy) lows++; end
    check("after_rst_idle", 32'(lows), 32'd0);
    check("after_rst_no_resend", 32'(n_resend), 32'd0);

    // single write
    clear_mon();
    pulse_start();
    wait_done(5000);
    check("single_frames", 32'(frames.size()), 32'd1);
    if (frames.size() >= 1) begin
      check("single_rises", 32'(frames[0].n), 32'd27);
      check("single_dev", 32'(frames[0].d[26:19]), 32'h42);
      check("single_reg", 32'(frames[0].d[17:10]), 32'h12);
      check("single_val", 32'(frames[0].d[8:1]), 32'h80);
      check("single_oe_mask", frames[0].o & 32'h07FF_FFFF, 32'h07FB_FDFE);
      check("single_adv_lat", 32'(last_adv_cyc - frames[0].sc), 32'd232);
    end
    check("single_done_busy", {30'd0, done, busy}, 32'd2);
    check("single_count", 32'(cmd_count), 32'd1);
    check("single_resend", 32'(n_resend), 32'd1);

    // delay entry between two writes
    load4(16'h1280, 16'hFFF0, 16'h1200, 16'hFFFF);
    clear_mon();
    pulse_start();
    wait_done(5000);
    check("delay_frames", 32'(frames.size()), 32'd2);
    if (frames.size() >= 2)
      check("delay_gap_ge100", 32'(frames[1].sc - first_adv_cyc >= 100), 32'd1);
    check("delay_sioc_high", 32'(gap_lows), 32'd0);
    frames_vs_rom(nmis);
    check("delay_frame_data", 32'(nmis), 32'd0);
    check("delay_count", 32'(cmd_count), 32'd2);

    // start while busy is ignored
    load4(16'h1280, 16'h1200, 16'hFFFF, 16'hFFFF);
    clear_mon();
    pulse_start();
    i = 0;
    while (!(in_frame && nbits >= 3) && i < 5000) begin @(negedge clk); i++; end
    pulse_start();
    wait_done(5000);
    check("busy_start_resend", 32'(n_resend), 32'd1);
    check("busy_start_count", 32'(cmd_count), 32'd2);
    check("busy_start_frames", 32'(frames.size()), 32'd2);

    // full register table
    load_full();
    clear_mon();
    pulse_start();
    wait_done(30000);
    check("full_count", 32'(cmd_count), 32'd73);
    frames_vs_rom(nmis);
    check("full_frame_data", 32'(nmis), 32'd0);
    lows = 0;
    repeat (200) begin @(negedge clk); if (!done || busy) lows++; end
    check("full_done_holds", 32'(lows), 32'd0);

    // restart after done
    clear_mon();
    pulse_start();
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_count_clr", 32'(cmd_count), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    wait_done(30000);
    check("restart_resend", 32'(n_resend), 32'd1);
    check("restart_count", 32'(cmd_count), 32'd73);
    frames_vs_rom(nmis);
    check("restart_frame_data", 32'(nmis), 32'd0);

    check("resend_adv_overlap", 32'(n_both), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
